// File: rtl/trace_capture_buffer_if.sv
// Handshake bundle between the fetch monitor, the trace capture buffer and the trace export port.
// The buffer uses the slave view, and the driving environment uses the master view.
interface trace_capture_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 32
);
    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [TS_WIDTH-1:0]   out_ts;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_gap;

    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  out_valid, out_ts, out_addr, out_data, out_gap
    );

    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output out_valid, out_ts, out_addr, out_data, out_gap
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// Timestamped circular trace FIFO between the instruction fetch monitor and the trace export port.
// It counts records dropped on overflow and flags the first record stored after any loss.
module trace_capture_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH      = 16,
    parameter int DROP_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture_en,
    input  logic                   flush,
    trace_capture_buffer_if.slave  bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic [DROP_WIDTH-1:0]  drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {EMPTY, NONEMPTY} state_t;

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  gap;
    } entry_t;

    entry_t                mem_q [DEPTH];
    entry_t                head;
    state_t                state_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic                  gap_q, gap_d;
    logic                  push, pop, accept, drop;

    assign full   = (level_q == LW'(DEPTH));
    assign push   = bus.in_valid & capture_en & ~flush;
    assign pop    = (state_q == NONEMPTY) & bus.out_ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // A flush overrides any same-cycle push or pop, and it counts as a loss when it discards records.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        gap_d    = gap_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            if (level_q != '0) gap_d = 1'b1;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                gap_d    = 1'b0;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (accept && !pop)      level_d = level_q + LW'(1);
            else if (pop && !accept) level_d = level_q - LW'(1);
            if (drop) begin
                gap_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            gap_q    <= 1'b0;
        end else begin
            ts_q     <= ts_q + TS_WIDTH'(1);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            gap_q    <= gap_d;
            case (state_q)
                EMPTY:    if (accept) state_q <= NONEMPTY;
                NONEMPTY: if (flush || (pop && !accept && level_q == LW'(1))) state_q <= EMPTY;
                default:  state_q <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) mem_q[wr_ptr_q] <= '{ts: ts_q, addr: bus.in_addr, data: bus.in_data, gap: gap_q};
    end

    // Storage is not reset, so the head is masked while empty to keep the export fields at zero.
    assign head          = (state_q == NONEMPTY) ? mem_q[rd_ptr_q] : '0;
    assign bus.out_valid = (state_q == NONEMPTY);
    assign bus.out_ts    = head.ts;
    assign bus.out_addr  = head.addr;
    assign bus.out_data  = head.data;
    assign bus.out_gap   = head.gap;
    assign level         = level_q;
    assign drop_count    = drop_q;
endmodule
